// File: rtl/mvm_ctrl_pipe_if.sv
// mvm_ctrl_pipe_if: job request, config, stall and read/accumulate control bundle for mvm_ctrl_pipe.
interface mvm_ctrl_pipe_if #(
    parameter int VEC_ADDRW = 8,
    parameter int VEC_SIZEW = 9,
    parameter int MAT_ADDRW = 9,
    parameter int MAT_SIZEW = 10,
    parameter int BATCHW    = 4
) ();
    logic                 start;
    logic [VEC_ADDRW-1:0] vec_start_addr;
    logic [VEC_SIZEW-1:0] vec_num_words;
    logic [MAT_ADDRW-1:0] mat_start_addr;
    logic [MAT_SIZEW-1:0] mat_num_rows_per_olane;
    logic [BATCHW-1:0]    batch_size;
    logic                 stall;
    logic                 rd_en;
    logic [VEC_ADDRW-1:0] vec_raddr;
    logic [MAT_ADDRW-1:0] mat_raddr;
    logic                 accum_first;
    logic                 accum_last;
    logic                 ovalid;
    logic                 busy;
    logic                 done;
    logic                 cfg_err;
    modport master (
        output start, vec_start_addr, vec_num_words, mat_start_addr, mat_num_rows_per_olane,
               batch_size, stall,
        input  rd_en, vec_raddr, mat_raddr, accum_first, accum_last, ovalid, busy, done, cfg_err
    );
    modport slave (
        input  start, vec_start_addr, vec_num_words, mat_start_addr, mat_num_rows_per_olane,
               batch_size, stall,
        output rd_en, vec_raddr, mat_raddr, accum_first, accum_last, ovalid, busy, done, cfg_err
    );
endinterface

// File: rtl/mvm_ctrl_pipe.sv
// mvm_ctrl_pipe: batched MVM read sequencer with latency-aligned accumulate flags and stall support.
module mvm_ctrl_pipe #(
    parameter int VEC_ADDRW = 8,
    parameter int VEC_SIZEW = 9,
    parameter int MAT_ADDRW = 9,
    parameter int MAT_SIZEW = 10,
    parameter int BATCHW    = 4,
    parameter int PIPE_LAT  = 3
) (
    input logic clk,
    input logic rst,
    mvm_ctrl_pipe_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    state_t state, state_nx;
    logic [VEC_SIZEW-1:0] words, w_cnt;
    logic [MAT_SIZEW-1:0] rows, r_cnt;
    logic [BATCHW-1:0]    batch, b_cnt;
    logic [VEC_ADDRW-1:0] vec_ptr, vec_base;
    logic [MAT_ADDRW-1:0] mat_ptr, mat_base;
    logic [PIPE_LAT-1:0]  dv, df, dl;
    logic ov_q, cfg_err_q, run, cfg_ok, accept, w_end, r_end, b_end, job_end, rd_en, done_c;
    assign run     = !bus.stall;
    assign cfg_ok  = |bus.vec_num_words && |bus.mat_num_rows_per_olane && |bus.batch_size;
    assign accept  = state == IDLE && bus.start && run && cfg_ok;
    assign w_end   = w_cnt == words - 1'b1;
    assign r_end   = r_cnt == rows - 1'b1;
    assign b_end   = b_cnt == batch - 1'b1;
    assign job_end = w_end && r_end && b_end;
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end
    always_comb begin
        state_nx = state == IDLE  ? (accept ? ISSUE : IDLE) :
                   state == ISSUE ? (rd_en && job_end ? DRAIN : ISSUE) :
                                    (done_c ? IDLE : DRAIN);
    end
    // The final ovalid is the only one seen with an empty delay line in DRAIN.
    always_comb begin
        rd_en           = state == ISSUE && run;
        done_c          = state == DRAIN && run && ov_q && dv == '0;
        bus.rd_en       = rd_en;
        bus.done        = done_c;
        bus.busy        = state != IDLE;
        bus.vec_raddr   = vec_ptr;
        bus.mat_raddr   = mat_ptr;
        bus.accum_first = run && dv[PIPE_LAT-1] && df[PIPE_LAT-1];
        bus.accum_last  = run && dv[PIPE_LAT-1] && dl[PIPE_LAT-1];
        bus.ovalid      = run && ov_q;
        bus.cfg_err     = cfg_err_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            words     <= '0;
            rows      <= '0;
            batch     <= '0;
            w_cnt     <= '0;
            r_cnt     <= '0;
            b_cnt     <= '0;
            vec_ptr   <= '0;
            vec_base  <= '0;
            mat_ptr   <= '0;
            mat_base  <= '0;
            dv        <= '0;
            df        <= '0;
            dl        <= '0;
            ov_q      <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= state == IDLE && bus.start && run && !cfg_ok;
            if (run) begin
                dv   <= PIPE_LAT'({dv, rd_en});
                df   <= PIPE_LAT'({df, w_cnt == '0});
                dl   <= PIPE_LAT'({dl, w_end});
                ov_q <= dv[PIPE_LAT-1] && dl[PIPE_LAT-1];
            end
            if (accept) begin
                words    <= bus.vec_num_words;
                rows     <= bus.mat_num_rows_per_olane;
                batch    <= bus.batch_size;
                w_cnt    <= '0;
                r_cnt    <= '0;
                b_cnt    <= '0;
                vec_ptr  <= bus.vec_start_addr;
                vec_base <= bus.vec_start_addr;
                mat_ptr  <= bus.mat_start_addr;
                mat_base <= bus.mat_start_addr;
            end else if (rd_en) begin
                // Running pointers: next row rewinds the vector, next batch rewinds the matrix.
                if (!w_end) begin
                    w_cnt   <= w_cnt + 1'b1;
                    vec_ptr <= vec_ptr + 1'b1;
                    mat_ptr <= mat_ptr + 1'b1;
                end else if (!r_end) begin
                    w_cnt   <= '0;
                    r_cnt   <= r_cnt + 1'b1;
                    vec_ptr <= vec_base;
                    mat_ptr <= mat_ptr + 1'b1;
                end else begin
                    w_cnt    <= '0;
                    r_cnt    <= '0;
                    b_cnt    <= b_cnt + 1'b1;
                    vec_ptr  <= vec_ptr + 1'b1;
                    vec_base <= vec_ptr + 1'b1;
                    mat_ptr  <= mat_base;
                end
            end
        end
    end
endmodule

// File: doc/mvm_ctrl_pipe.md
# mvm_ctrl_pipe

Parametrised sequencing controller for the matrix-vector multiplier datapath. It walks the vector and matrix buffers over a batch of input vectors, issuing one read per cycle. It emits `accum_first` / `accum_last` delayed by a configurable datapath latency so they line up with products arriving at the accumulators, and it raises `ovalid` once per completed output row. It adds batching, latency alignment, stall support and configuration checking over the single-pass controller.

## Interface
- `VEC_ADDRW`, 8: vector buffer address width.
- `VEC_SIZEW`, 9: width of `vec_num_words`.
- `MAT_ADDRW`, 9: matrix buffer address width.
- `MAT_SIZEW`, 10: width of `mat_num_rows_per_olane`.
- `BATCHW`, 4: width of `batch_size`.
- `PIPE_LAT`, 3: cycles from read issue to product at accumulator input; must be 1 or more.

Ports (clock and reset first):
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: job request, sampled only in IDLE.
- `vec_start_addr` in VEC_ADDRW: base address of vector 0.
- `vec_num_words` in VEC_SIZEW: words per vector (inner loop count).
- `mat_start_addr` in MAT_ADDRW: matrix base address.
- `mat_num_rows_per_olane` in MAT_SIZEW: rows per output lane.
- `batch_size` in BATCHW: number of vectors per job.
- `stall` in 1: freezes the whole controller for that cycle.
- `rd_en` out 1: buffer read strobe.
- `vec_raddr` out VEC_ADDRW: vector read address.
- `mat_raddr` out MAT_ADDRW: matrix read address.
- `accum_first` out 1: clear-and-accumulate, latency-aligned.
- `accum_last` out 1: final word of a row, latency-aligned.
- `ovalid` out 1: accumulator result valid.
- `busy` out 1: job in progress.
- `done` out 1: one-cycle end-of-job pulse.
- `cfg_err` out 1: one-cycle pulse when `start` is rejected.

## Operation
- All config inputs are captured into registers on the accepted `start`. They may change freely afterwards.
- States:
  - IDLE:
    - `start`=1 with all of `vec_num_words`, `mat_num_rows_per_olane`, `batch_size` nonzero → ISSUE, capture config, `busy`=1.
    - `start`=1 with any of those three fields zero → stay IDLE, pulse `cfg_err`.
  - ISSUE: one read per non-stalled cycle. After the last read of the job → DRAIN.
  - DRAIN: wait until the delay line is empty and the final `ovalid` has been emitted, then → IDLE.
- Loop order: batch b (outer), row r (middle), word w (inner). Ranges are b in 0..batch_size-1, r in 0..rows-1, w in 0..words-1.
- Address generation:
  - `vec_raddr` = vec_start_addr + b*words + w.
  - `mat_raddr` = mat_start_addr + r*words + w. The matrix pointer restarts at `mat_start_addr` for every b.
  - Use running pointers only, no multipliers. Both addresses wrap modulo 2^width silently.
- Issue-stage flags: first = (w==0), last = (w==words-1). For `words`=1 both flags are set on the same read.
- A PIPE_LAT-deep shift register carries (valid, first, last). Its output drives `accum_first` and `accum_last`, each gated by valid.
- `ovalid` is a register of the delayed (valid & last), so it fires 1 cycle after `accum_last`.
- `done` pulses in the same cycle as the final `ovalid`. `busy` drops the following cycle.
- `stall`=1 holds the state, all counters, address outputs and the delay line. During a stall `rd_en`, `accum_first`, `accum_last`, `ovalid` and `done` are forced to 0, and pending pulses resume after the stall.
- `start` while `busy` is ignored: no `cfg_err`, no restart.
- `rst` at any time: next cycle IDLE, delay line flushed, no `ovalid` or `done` from the aborted job.

## Timing
- Reset values: `rd_en`, `vec_raddr`, `mat_raddr`, `accum_first`, `accum_last`, `ovalid`, `busy`, `done`, `cfg_err` are all 0.
- Accepted `start` high at edge k:
  - `busy`=1 and the first `rd_en` in cycle k+1.
  - First `accum_first` in cycle k+1+PIPE_LAT.
- Reads are back-to-back with no bubbles between words, rows or batches. Total reads = batch_size*rows*words.
- Without stalls:
  - The last read is in cycle k+N, where N = batch_size*rows*words.
  - The final `accum_last` is in cycle k+N+PIPE_LAT.
  - The final `ovalid` and `done` are in cycle k+N+PIPE_LAT+1.
  - `busy` is 0 from cycle k+N+PIPE_LAT+2.
- Each stall cycle delays every subsequent event by exactly 1 cycle.
- `ovalid` count per job = batch_size*rows.
- `cfg_err` asserts in the cycle after the rejected `start`.
- A new `start` is accepted in the first cycle `busy`=0.

## Test plan
- Basic job: words=16, rows=16, batch=1, PIPE_LAT=3, start at cycle 10, all bases 0.
  - Expect 256 reads.
  - `mat_raddr` runs 0..255, `vec_raddr` repeats 0..15.
  - 16 `ovalid` pulses.
  - `done` at cycle 10+256+4=270.
- Batch and wrap: vec_start=250, words=4, rows=2, batch=3.
  - `vec_raddr` sequence is 250..253 twice, 254,255,0,1 twice, 2..5 twice.
  - `mat_raddr` restarts at mat_start for each vector.
  - 6 `ovalid` pulses.
- Single word: words=1, rows=3, batch=1.
  - `accum_first` and `accum_last` are both high on 3 consecutive aligned cycles.
  - 3 `ovalid` pulses, each one cycle later.
- Stall: 5-cycle `stall` mid-row on the basic job.
  - Addresses are frozen during the stall.
  - No `accum_first`, `accum_last` or `ovalid` during the stall.
  - `done` arrives exactly 5 cycles late.
  - Sequence is otherwise identical to the basic job.
- Config error and ignored start:
  - start with batch=0 → `cfg_err` pulse, `busy` stays 0.
  - start pulsed during a job → no effect on the job.
- Reset mid-job: `rst` at read 100 of the basic job.
  - Next cycle all outputs are 0.
  - No later `ovalid`.
  - A new start runs a clean job.
